// File: rtl/acc_pkg.sv
// Shared types and the op helper for the accumulating logic register with undo.
package acc_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_XOR = 2'b01,
    OP_OR  = 2'b10,
    OP_ADD = 2'b11
  } op_t;

  // Widest accumulator the helper supports; callers zero-extend and slice back.
  localparam int MAX_W = 64;

  // Returns {carry, value}; bit W of the result is the W-bit add carry for W < MAX_W.
  function automatic logic [MAX_W:0] apply_op(
    input op_t              op,
    input logic [MAX_W-1:0] q,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b
  );
    logic [MAX_W:0] res;
    res = '0;
    case (op)
      OP_AND:  res = {1'b0, q & b};
      OP_XOR:  res = {1'b0, q ^ a};
      OP_OR:   res = {1'b0, q | a};
      default: res = {1'b0, q} + {1'b0, a};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/acc_logic_undo_hist_lifo.sv
// Circular LIFO of past accumulator values; a push when full overwrites the oldest slot.
module hist_lifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          r,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] top_ptr;

  // Newest entry sits just below the write pointer; wrap is free since DEPTH is 2^AW.
  assign top_ptr = wp - AW'(1);
  assign dout    = mem[top_ptr];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (r) begin
      wp  <= '0;
      cnt <= '0;
    end else if (pop && !empty) begin
      wp  <= top_ptr;
      cnt <= cnt - CW'(1);
    end else if (push) begin
      wp <= wp + AW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (!r && push && !pop) mem[wp] <= din;
  end

endmodule

// File: rtl/acc_logic_undo.sv
// Accumulating logic register with DEPTH-entry undo history.
// Optional macro ACC_ADD_EN enables op 11 (Q+A with carry); otherwise op 11 is a no-op.
module acc_logic_undo
  import acc_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          r,
  input  logic          enable,
  input  op_t           op,
  input  logic          undo,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic [W-1:0]  Q,
  output logic [W/2-1:0] L,
  output logic [CW-1:0] hist_cnt,
  output logic          empty,
  output logic          full,
  output logic          undo_err,
  output logic          carry
);

  logic           op_ok;
  logic           push;
  logic           pop;
  logic [W-1:0]   hist_top;
  logic [MAX_W:0] op_res;
  logic           unused_ok;

  assign L = A[W-1:W/2];

`ifdef ACC_ADD_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = (op != OP_ADD);
`endif

  // undo outranks enable: a simultaneous op is dropped and nothing is pushed.
  assign push = enable && !undo && op_ok;
  assign pop  = undo && !empty;

  assign op_res    = apply_op(op, MAX_W'(Q), MAX_W'(A), MAX_W'(B));
  assign unused_ok = &{1'b0, op_res};

  hist_lifo #(.W(W), .DEPTH(DEPTH)) u_hist (
    .clk   (clk),
    .r     (r),
    .push  (push),
    .pop   (pop),
    .din   (Q),
    .dout  (hist_top),
    .cnt   (hist_cnt),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      Q        <= '0;
      undo_err <= 1'b0;
    end else begin
      undo_err <= undo && empty;
      if (pop)       Q <= hist_top;
      else if (push) Q <= op_res[W-1:0];
    end
  end

`ifdef ACC_ADD_EN
  always_ff @(posedge clk) begin
    if (r)                        carry <= 1'b0;
    else if (push && op == OP_ADD) carry <= op_res[W];
  end
`else
  assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_acc_logic_undo.sv
// Directed plan plus randomized traffic against a queue-based reference of acc_logic_undo.
module tb_acc_logic_undo;
  import acc_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          r = 1'b1;
  logic          enable = 1'b0;
  op_t           op = OP_AND;
  logic          undo = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [W-1:0]  Q;
  logic [W/2-1:0] L;
  logic [CW-1:0] hist_cnt;
  logic          empty, full, undo_err, carry;

  int n_chk  = 0;
  int n_fail = 0;

  // reference state
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_hist [$];
  logic         m_err = 1'b0;
  logic         m_carry = 1'b0;

`ifdef ACC_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  acc_logic_undo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .r(r), .enable(enable), .op(op), .undo(undo), .A(A), .B(B),
    .Q(Q), .L(L), .hist_cnt(hist_cnt), .empty(empty), .full(full),
    .undo_err(undo_err), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [W:0] sum;
    if (r) begin
      m_q = '0; m_hist.delete(); m_err = 1'b0; m_carry = 1'b0;
    end else if (undo) begin
      if (m_hist.size() > 0) begin
        m_q = m_hist.pop_back(); m_err = 1'b0;
      end else m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (enable && (op != OP_ADD || ADD_EN)) begin
        m_hist.push_back(m_q);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        case (op)
          OP_AND: m_q = m_q & B;
          OP_XOR: m_q = m_q ^ A;
          OP_OR:  m_q = m_q | A;
          default: begin
            sum = {1'b0, m_q} + {1'b0, A};
            m_q = sum[W-1:0]; m_carry = sum[W];
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    chk("Q", Q, m_q);
    chk("hist_cnt", hist_cnt, m_hist.size());
    chk("empty", empty, m_hist.size() == 0);
    chk("full", full, m_hist.size() == DEPTH);
    chk("undo_err", undo_err, m_err);
    chk("carry", carry, m_carry);
    chk("L", L, A[W-1:W/2]);
  endtask

  // Drive one cycle's inputs, clock it, then compare just after the edge.
  task automatic cyc(input logic rr, input logic en, input op_t o, input logic u,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    r = rr; enable = en; op = o; undo = u; A = a; B = b;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    // 1. reset, then reset mid-sequence
    cyc(1, 1, OP_XOR, 0, 8'h5A, 8'h11);
    cyc(1, 0, OP_OR, 1, 8'h77, 8'h22);
    chk("rst_Q", Q, 8'h00); chk("rst_cnt", hist_cnt, 0);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_err", undo_err, 0);
    cyc(0, 1, OP_XOR, 0, 8'h01, 0);
    cyc(0, 1, OP_XOR, 0, 8'h02, 0);
    cyc(0, 1, OP_XOR, 0, 8'h04, 0);
    chk("mid_cnt", hist_cnt, 3);
    cyc(1, 0, OP_AND, 0, 0, 0);
    chk("mid_rst_Q", Q, 8'h00); chk("mid_rst_cnt", hist_cnt, 0); chk("mid_rst_empty", empty, 1);

    // 2. op/undo chain
    cyc(0, 1, OP_XOR, 0, 8'hA5, 0); chk("chain_xor", Q, 8'hA5);
    cyc(0, 1, OP_OR,  0, 8'h0F, 0); chk("chain_or", Q, 8'hAF);
    cyc(0, 1, OP_AND, 0, 0, 8'hF0); chk("chain_and", Q, 8'hA0);
    chk("chain_cnt", hist_cnt, 3);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("chain_u1", Q, 8'hAF);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("chain_u2", Q, 8'hA5);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("chain_u3", Q, 8'h00);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("chain_u4_err", undo_err, 1); chk("chain_u4_Q", Q, 8'h00);
    cyc(0, 0, OP_AND, 0, 0, 0); chk("chain_err_clr", undo_err, 0);

    // 3. overwrite oldest
    for (int i = 0; i < 6; i++) cyc(0, 1, OP_XOR, 0, 8'(1 << i), 0);
    chk("ovw_Q", Q, 8'h3F); chk("ovw_cnt", hist_cnt, 4); chk("ovw_full", full, 1);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("ovw_u1", Q, 8'h1F);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("ovw_u2", Q, 8'h0F);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("ovw_u3", Q, 8'h07);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("ovw_u4", Q, 8'h03);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("ovw_u5_err", undo_err, 1); chk("ovw_u5_Q", Q, 8'h03);
    cyc(0, 0, OP_AND, 1, 0, 0); chk("ovw_held_err", undo_err, 1);

    // 4. undo and enable together
    cyc(1, 0, OP_AND, 0, 0, 0);
    cyc(0, 1, OP_XOR, 0, 8'h30, 0);
    cyc(0, 1, OP_XOR, 0, 8'h0C, 0);
    chk("sim_pre_Q", Q, 8'h3C);
    cyc(0, 1, OP_XOR, 1, 8'hFF, 0);
    chk("sim_Q", Q, 8'h30); chk("sim_cnt", hist_cnt, 1);

    // 5. hold and L
    r = 0; enable = 0; undo = 0; A = 8'hC3; #1;
    chk("L_comb", L, 4'hC);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, OP_XOR, 0, 8'hC3, 8'h00);
      chk("hold_Q", Q, 8'h30); chk("hold_cnt", hist_cnt, 1);
    end

    // 6. op 11
    cyc(1, 0, OP_AND, 0, 0, 0);
    cyc(0, 1, OP_XOR, 0, 8'hF0, 0);
    cyc(0, 1, OP_ADD, 0, 8'h20, 0);
`ifdef ACC_ADD_EN
    chk("add_Q", Q, 8'h10); chk("add_carry", carry, 1); chk("add_cnt", hist_cnt, 2);
    cyc(0, 0, OP_AND, 1, 0, 0);
    chk("add_undo_Q", Q, 8'hF0); chk("add_undo_carry", carry, 1);
`else
    chk("noadd_Q", Q, 8'hF0); chk("noadd_cnt", hist_cnt, 1); chk("noadd_carry", carry, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 50) == 0, $urandom % 2, op_t'($urandom % 4), ($urandom % 4) == 0,
          W'($urandom), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
